switch_allocator: RTL

Per-router switch allocator that drives the 7-port crossbar's select lines. Each cycle it matches input ports that hold a flit to the output ports they request. Each output has its own round-robin arbiter and a wormhole packet lock, so a multi-flit packet owns its output from head to tail. It sits between the input buffers / routing-computation stage and the crossbar: `xbar_dest` feeds the crossbar `dest` vector, and `gnt` pops the input buffers.

---
 rtl/switch_allocator.sv | 102 ++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin crossbar allocator with wormhole packet locks.
// Define SWALLOC_STATS_EN to add the saturating per-output conflict_cnt counters.
module switch_allocator #(
    parameter int INPUTS = 7,
    parameter int PW     = $clog2(INPUTS),
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS-1:0]            req,
    input  logic [INPUTS-1:0][PW-1:0]    req_port,
    input  logic [INPUTS-1:0]            req_tail,
    input  logic [INPUTS-1:0]            out_ready,
    output logic [INPUTS-1:0]            gnt,
    output logic [INPUTS-1:0][PW-1:0]    xbar_dest,
    output logic [INPUTS-1:0]            out_valid
`ifdef SWALLOC_STATS_EN
    ,
    output logic [INPUTS-1:0][CNT_W-1:0] conflict_cnt
`endif
);
    logic [INPUTS-1:0][PW-1:0] rr, owner, win;
    logic [INPUTS-1:0]         locked, owns;

    always_comb begin
        logic          found;
        logic [PW-1:0] pick;
        int            idx;
        found = 1'b0;
        pick = '0;
        idx = 0;
        owns = '0;
        gnt = '0;
        out_valid = '0;
        win = '0;
        for (int i = 0; i < INPUTS; i++) xbar_dest[i] = PW'(INPUTS);
        for (int o = 0; o < INPUTS; o++)
            if (locked[o]) owns[owner[o]] = 1'b1;
        for (int o = 0; o < INPUTS; o++) begin
            found = 1'b0;
            pick = owner[o];
            if (locked[o]) begin
                found = req[owner[o]] && int'(req_port[owner[o]]) == o;
            end else begin
                // lock owners are masked so they cannot grab a second output
                for (int k = 0; k < INPUTS; k++) begin
                    idx = (int'(rr[o]) + k) % INPUTS;
                    if (!found && req[idx] && int'(req_port[idx]) == o && !owns[idx]) begin
                        found = 1'b1;
                        pick = PW'(idx);
                    end
                end
            end
            if (found && out_ready[o] && !rst) begin
                out_valid[o] = 1'b1;
                gnt[pick] = 1'b1;
                xbar_dest[pick] = PW'(o);
                win[o] = pick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
            locked <= '0;
            owner <= '0;
        end else begin
            for (int o = 0; o < INPUTS; o++) begin
                if (out_valid[o]) begin
                    if (req_tail[win[o]]) begin
                        locked[o] <= 1'b0;
                        rr[o] <= PW'((int'(win[o]) + 1) % INPUTS);
                    end else if (!locked[o]) begin
                        locked[o] <= 1'b1;
                        owner[o] <= win[o];
                    end
                end
            end
        end
    end

`ifdef SWALLOC_STATS_EN
    logic [INPUTS-1:0] conflict;

    always_comb begin
        conflict = '0;
        for (int o = 0; o < INPUTS; o++)
            for (int i = 0; i < INPUTS; i++)
                if (req[i] && int'(req_port[i]) == o && !gnt[i]) conflict[o] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else begin
            for (int o = 0; o < INPUTS; o++)
                if (conflict[o] && !(&conflict_cnt[o])) conflict_cnt[o] <= conflict_cnt[o] + 1'b1;
        end
    end
`endif
endmodule
